oam_dma_ctrl: RTL

- Sequences the DMG OAM DMA transfer. A CPU write to the DMA register (0xFF46) with value X copies 160 bytes from source X00..X9F into OAM (0xFE00..0xFE9F).
- Acts as a bus master on the system read port and drives the OAM write port of whizgraphics directly.
- Asserts a block signal so the CPU bus mux diverts CPU traffic away from the shared bus for the whole transfer.

---
 rtl/oam_dma_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - DMG OAM DMA sequencer: copies one 160-byte source page into OAM
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR    = 16'hFF46,
   parameter int          XFER_LEN        = 160,
   parameter int          CYCLES_PER_BYTE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   output logic [7:0]  dma_reg,
   output logic [15:0] src_addr,
   output logic        src_re,
   input  logic [7:0]  src_rdata,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_wdata,
   output logic        oam_we,
   output logic        dma_active,
   output logic        cpu_block
);

   localparam int PHASE_W = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 2;
   localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(CYCLES_PER_BYTE - 1);
   localparam logic [PHASE_W-1:0] PHASE_READ  = PHASE_W'(0);
   localparam logic [PHASE_W-1:0] PHASE_CAPT  = PHASE_W'(1);
   localparam logic [PHASE_W-1:0] PHASE_WRITE = PHASE_W'(2);
   localparam logic [PHASE_W-1:0] PHASE_ONE   = PHASE_W'(1);
   localparam logic [7:0]         INDEX_LAST  = 8'(XFER_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_XFER  = 2'd2
   } state_t;

   state_t             state_q,      state_d;
   logic [PHASE_W-1:0] phase_q,      phase_d;
   logic [7:0]         index_q,      index_d;
   logic [7:0]         src_hi_q,     src_hi_d;
   logic [7:0]         dma_reg_q,    dma_reg_d;
   logic [15:0]        src_addr_q,   src_addr_d;
   logic               src_re_q,     src_re_d;
   logic [7:0]         oam_addr_q,   oam_addr_d;
   logic [7:0]         oam_wdata_q,  oam_wdata_d;
   logic               oam_we_q,     oam_we_d;
   logic               dma_active_q, dma_active_d;

   logic               reg_wr;
   logic [7:0]         src_hi_new;

   // Decode the DMA register write and fold echo-RAM pages E0..FF back onto C0..DF
   always_comb begin
      reg_wr     = cpu_we && (cpu_addr == DMA_REG_ADDR);
      src_hi_new = (cpu_wdata < 8'hE0) ? cpu_wdata : (cpu_wdata & 8'hDF);
   end

   // Next-state sequencing plus outputs derived from the next state so they register cleanly
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      index_d      = index_q;
      src_hi_d     = src_hi_q;
      dma_reg_d    = dma_reg_q;
      src_addr_d   = src_addr_q;
      src_re_d     = 1'b0;
      oam_addr_d   = oam_addr_q;
      oam_wdata_d  = oam_wdata_q;
      oam_we_d     = 1'b0;
      dma_active_d = dma_active_q;

      case (state_q)
         ST_IDLE: begin
            phase_d = '0;
         end
         ST_START: begin
            if (phase_q == PHASE_LAST) begin
               state_d = ST_XFER;
               phase_d = '0;
               index_d = 8'd0;
            end else begin
               phase_d = phase_q + PHASE_ONE;
            end
         end
         ST_XFER: begin
            // Read data arrives one clock after the read strobe, i.e. during phase 1
            if (phase_q == PHASE_CAPT) begin
               oam_wdata_d = src_rdata;
            end
            if (phase_q == PHASE_LAST) begin
               phase_d = '0;
               if (index_q == INDEX_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  index_d = index_q + 8'd1;
               end
            end else begin
               phase_d = phase_q + PHASE_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            phase_d = '0;
         end
      endcase

      // A register write always wins, including over the final byte's last phase
      if (reg_wr) begin
         dma_reg_d = cpu_wdata;
         src_hi_d  = src_hi_new;
         state_d   = ST_START;
         phase_d   = '0;
         index_d   = 8'd0;
      end

      if ((state_d == ST_XFER) && (phase_d == PHASE_READ)) begin
         src_re_d   = 1'b1;
         src_addr_d = {src_hi_d, index_d};
      end
      if ((state_d == ST_XFER) && (phase_d == PHASE_WRITE)) begin
         oam_we_d   = 1'b1;
         oam_addr_d = index_d;
      end
      dma_active_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset aborts any transfer immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         phase_q      <= '0;
         index_q      <= 8'd0;
         src_hi_q     <= 8'd0;
         dma_reg_q    <= 8'h00;
         src_addr_q   <= 16'd0;
         src_re_q     <= 1'b0;
         oam_addr_q   <= 8'd0;
         oam_wdata_q  <= 8'd0;
         oam_we_q     <= 1'b0;
         dma_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         index_q      <= index_d;
         src_hi_q     <= src_hi_d;
         dma_reg_q    <= dma_reg_d;
         src_addr_q   <= src_addr_d;
         src_re_q     <= src_re_d;
         oam_addr_q   <= oam_addr_d;
         oam_wdata_q  <= oam_wdata_d;
         oam_we_q     <= oam_we_d;
         dma_active_q <= dma_active_d;
      end
   end

   assign dma_reg    = dma_reg_q;
   assign src_addr   = src_addr_q;
   assign src_re     = src_re_q;
   assign oam_addr   = oam_addr_q;
   assign oam_wdata  = oam_wdata_q;
   assign oam_we     = oam_we_q;
   assign dma_active = dma_active_q;
   assign cpu_block  = dma_active_q;

endmodule
